// File: rtl/alu_pkg.sv
// Shared op-codes, FSM state encoding and status bit positions for the
// sequential ALU.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOR = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_BUSY = 2'd1,
        ST_DONE     = 2'd2
    } state_t;

    localparam int ST_Z = 0;
    localparam int ST_N = 1;
    localparam int ST_V = 2;

    function automatic logic [2:0] make_status(input logic v, input logic n, input logic z);
        logic [2:0] s;
        s       = '0;
        s[ST_V] = v;
        s[ST_N] = n;
        s[ST_Z] = z;
        return s;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle,
// LSB first, fixed WIDTH-cycle latency regardless of operand values.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            cnt    <= CNT_W'(WIDTH);
        end else if (cnt != '0) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CNT_W'(1);
        end
    end

    // Terminal count; only meaningful to the FSM while a multiply is in flight.
    assign done    = (cnt == '0);
    assign product = acc;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith ops plus iterative multiply,
// registered result and {V,N,Z} status held until consumed.
//
//   state       | meaning
//   ST_IDLE     | no result pending, ready for a request
//   ST_MUL_BUSY | multiplier iterating, requests blocked
//   ST_DONE     | result valid, waiting for out_ready
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       gin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             zout,
    output logic [2:0]       status
);

    state_t             state;
    state_t             state_nxt;
    logic               accept;
    logic               is_mul;
    logic [WIDTH-1:0]   add_r;
    logic [WIDTH-1:0]   sub_r;
    logic               add_v;
    logic               sub_v;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_v;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (gin == OP_MUL);
    assign out_valid = (state == ST_DONE);
    assign zout      = status[ST_Z];

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (accept && is_mul),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        add_r   = a + b;
        sub_r   = a - b;
        add_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_r[WIDTH-1] != a[WIDTH-1]);
        // SUB overflows when a and ~b share a sign that the result lacks.
        sub_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_r[WIDTH-1] != a[WIDTH-1]);
        alu_res = '0;
        alu_v   = 1'b0;
        case (gin)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_NOR: alu_res = ~(a | b);
            OP_ADD: begin
                alu_res = add_r;
                alu_v   = add_v;
            end
            OP_SUB: begin
                alu_res = sub_r;
                alu_v   = sub_v;
            end
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, sub_r[WIDTH-1] ^ sub_v};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = is_mul ? ST_MUL_BUSY : ST_DONE;
                end
            end
            ST_MUL_BUSY: begin
                if (mul_done) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (accept) begin
                    state_nxt = is_mul ? ST_MUL_BUSY : ST_DONE;
                end else if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            sum    <= '0;
            status <= '0;
        end else begin
            state <= state_nxt;
            if (accept && !is_mul) begin
                sum    <= alu_res;
                status <= make_status(alu_v, alu_res[WIDTH-1], alu_res == '0);
            end else if ((state == ST_MUL_BUSY) && mul_done) begin
                sum    <= mul_product[WIDTH-1:0];
                status <= make_status(|mul_product[2*WIDTH-1:WIDTH],
                                      mul_product[WIDTH-1],
                                      mul_product[WIDTH-1:0] == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: scoreboard of expected results checked on each output
// handshake, plus per-scenario inline checks; second instance at WIDTH=8.
module tb_alu_seq;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] sum;
        logic [2:0]  status;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, zout;
    logic [31:0] a, b, sum;
    logic [2:0]  gin, status;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, zout8;
    logic [7:0]  a8, b8, sum8;
    logic [2:0]  gin8, status8;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_out_cyc = 0;
    int   prev_out_cyc = 0;
    int   acc_cyc = 0;

    alu_seq #(.WIDTH(32)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .gin(gin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .zout(zout), .status(status)
    );

    alu_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .gin(gin8), .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .zout(zout8), .status(status8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        logic [63:0] p;
        longint      s;
        logic [31:0] r;
        logic        v;
        r = '0;
        v = 1'b0;
        case (op)
            OP_AND: r = x & y;
            OP_OR:  r = x | y;
            OP_XOR: r = x ^ y;
            OP_NOR: r = ~(x | y);
            OP_ADD: begin
                s = longint'($signed(x)) + longint'($signed(y));
                r = x + y;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_SUB: begin
                s = longint'($signed(x)) - longint'($signed(y));
                r = x - y;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_SLT: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: begin
                p = {32'd0, x} * {32'd0, y};
                r = p[31:0];
                v = (p[63:32] != 32'd0);
            end
        endcase
        e.sum    = r;
        e.status = {v, r[31], (r == 32'd0)};
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_output sum=%h status=%b, no result was expected", sum, status);
            end else begin
                e = exp_q.pop_front();
                if (sum !== e.sum || status !== e.status || zout !== e.status[0]) begin
                    errors++;
                    $display("FAIL sb_result got sum=%h status=%b zout=%b, expected sum=%h status=%b zout=%b",
                             sum, status, zout, e.sum, e.status, e.status[0]);
                end
            end
            prev_out_cyc = last_out_cyc;
            last_out_cyc = cyc;
        end
    end

    task automatic send(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        int n = 0;
        in_valid = 1'b1;
        gin = op;
        a = x;
        b = y;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready=%b, expected 1", in_ready);
        end else begin
            exp_q.push_back(model(op, x, y));
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || sum !== 32'd0 || status !== 3'b000 || zout !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state got ov=%b sum=%h st=%b z=%b ir=%b, expected 0 0 000 0 1",
                     out_valid, sum, status, zout, in_ready);
        end
        checks++;
        if (out_valid8 !== 1'b0 || sum8 !== 8'd0 || status8 !== 3'b000 || in_ready8 !== 1'b1) begin
            errors++;
            $display("FAIL reset_state8 got ov=%b sum=%h st=%b ir=%b, expected 0 00 000 1",
                     out_valid8, sum8, status8, in_ready8);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        send(OP_ADD, 32'd1, 32'd2);
        send(OP_SUB, 32'd3, 32'd2);
        wait_drain();
        checks++;
        if (last_out_cyc - prev_out_cyc !== 1) begin
            errors++;
            $display("FAIL b2b_spacing got %0d cycles, expected 1", last_out_cyc - prev_out_cyc);
        end
    endtask

    task automatic test_slt();
        send(OP_SLT, 32'hFFFF_FFFF, 32'd1);
        send(OP_SLT, 32'd1, 32'hFFFF_FFFF);
        send(OP_SLT, 32'h8000_0000, 32'h7FFF_FFFF);
        send(OP_SLT, 32'd5, 32'd5);
        wait_drain();
    endtask

    task automatic test_overflow();
        send(OP_ADD, 32'h7FFF_FFFF, 32'd1);
        send(OP_ADD, 32'hFFFF_FFFF, 32'd1);
        send(OP_SUB, 32'h8000_0000, 32'd1);
        send(OP_SUB, 32'd0, 32'h8000_0000);
        wait_drain();
    endtask

    task automatic test_logic();
        logic [2:0] ops [4] = '{OP_AND, OP_OR, OP_XOR, OP_NOR};
        for (int i = 0; i < 8; i++) begin
            send(ops[i % 4], $urandom, $urandom);
        end
        send(OP_ADD, $urandom, $urandom);
        send(OP_SUB, $urandom, $urandom);
        wait_drain();
    endtask

    task automatic test_mul();
        int n;
        bit ready_seen;
        send(OP_MUL, 32'h0000_FFFF, 32'h0001_0001);
        n = 0;
        ready_seen = 1'b0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            if (!out_valid && in_ready) ready_seen = 1'b1;
            n++;
        end
        checks++;
        if (cyc - acc_cyc !== 33) begin
            errors++;
            $display("FAIL mul_latency got %0d cycles, expected 33", cyc - acc_cyc);
        end
        checks++;
        if (ready_seen) begin
            errors++;
            $display("FAIL mul_in_ready got in_ready=1 while busy, expected 0");
        end
        wait_drain();
        send(OP_MUL, 32'h8000_0000, 32'd2);
        send(OP_MUL, 32'd0, 32'hDEAD_BEEF);
        send(OP_MUL, $urandom, $urandom);
        send(OP_ADD, 32'd4, 32'd5);
        wait_drain();
    endtask

    task automatic test_backpressure();
        int bad = 0;
        out_ready = 1'b0;
        send(OP_AND, 32'hFFFF_FFFF, 32'h0000_000F);
        in_valid = 1'b1;
        gin = OP_OR;
        a = 32'h1234_5678;
        b = 32'd0;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || sum !== 32'h0000_000F || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold got ov=%b sum=%h ir=%b, expected 1 0000000f 0",
                         out_valid, sum, in_ready);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        repeat (3) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL backpressure_ignored got %0d extra valid cycles, expected 0", bad);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_mul();
        int bad = 0;
        send(OP_MUL, 32'd3, 32'd5);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || sum !== 32'd0 || status !== 3'b000 || zout !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_state got ov=%b sum=%h st=%b z=%b ir=%b, expected 0 0 000 0 1",
                     out_valid, sum, status, zout, in_ready);
        end
        repeat (40) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL abort_no_pulse got %0d valid cycles, expected 0", bad);
        end
        @(posedge clk);
        #1;
        send(OP_ADD, 32'd1, 32'd2);
        wait_drain();
    endtask

    task automatic test_width8();
        logic [7:0] xa [2] = '{8'h7F, 8'hFF};
        logic [7:0] es [2] = '{8'h80, 8'h00};
        logic [2:0] et [2] = '{3'b110, 3'b001};
        for (int i = 0; i < 2; i++) begin
            in_valid8 = 1'b1;
            gin8 = OP_ADD;
            a8 = xa[i];
            b8 = 8'd1;
            @(posedge clk);
            #1;
            in_valid8 = 1'b0;
            @(negedge clk);
            checks++;
            if (out_valid8 !== 1'b1 || sum8 !== es[i] || status8 !== et[i] || zout8 !== et[i][0]) begin
                errors++;
                $display("FAIL w8_add got ov=%b sum=%h st=%b z=%b, expected 1 %h %b %b",
                         out_valid8, sum8, status8, zout8, es[i], et[i], et[i][0]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; gin = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; gin8 = '0;
        reset = 1'b1;
        test_reset();
        test_back_to_back();
        test_slt();
        test_overflow();
        test_logic();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        test_width8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
